// File: rtl/io_pkg.sv
// Shared constants for the conditioned switch/key input word read by the LSU.
package io_pkg;

  localparam int unsigned IO_WORD_W  = 32;
  localparam int unsigned SW_LSB     = 0;
  localparam int unsigned KEY_LSB    = 20;
  localparam int unsigned STICKY_LSB = 24;

  localparam logic [IO_WORD_W-1:0] IO_SW_ADDR = 32'h1001_0000;

endpackage

// File: rtl/debounce_bit.sv
// One raw input bit: 2-flop synchronizer, saturating stability counter and
// the accepted (stable) level.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_stable <= RESET_VAL;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/io_input_cond.sv
// Switch/button conditioning: debounce every raw bit, detect key presses,
// keep sticky press flags and pack everything into the LSU input word.
module io_input_cond
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SW_WIDTH        = 18,
  parameter int unsigned KEY_WIDTH       = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [KEY_WIDTH-1:0] i_key_raw_n,
  input  logic                 i_clr,
  input  logic [KEY_WIDTH-1:0] i_clr_mask,
  output logic [31:0]          o_io_sw,
  output logic [KEY_WIDTH-1:0] o_key_evt
);

  localparam int unsigned NB = SW_WIDTH + KEY_WIDTH;

  logic [NB-1:0]        w_raw;
  logic [NB-1:0]        w_stable;
  logic [KEY_WIDTH-1:0] w_key_pressed;
  logic [KEY_WIDTH-1:0] w_clr_bits;
  logic [31:0]          w_io_sw;

  logic [SW_WIDTH-1:0]  r_sw_lvl;
  logic [KEY_WIDTH-1:0] r_key_lvl;
  logic [KEY_WIDTH-1:0] r_key_evt;
  logic [KEY_WIDTH-1:0] r_sticky;

  assign w_raw = {i_key_raw_n, i_sw_raw};

  // Keys reset to their released raw level (1), switches to 0.
  for (genvar g = 0; g < NB; g++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       ((g >= SW_WIDTH) ? 1'b1 : 1'b0)
    ) u_db (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_raw    (w_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  assign w_key_pressed = ~w_stable[NB-1:SW_WIDTH];
  assign w_clr_bits    = i_clr ? i_clr_mask : '0;

  // A press event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sw_lvl  <= '0;
      r_key_lvl <= '0;
      r_key_evt <= '0;
      r_sticky  <= '0;
    end else begin
      r_sw_lvl  <= w_stable[SW_WIDTH-1:0];
      r_key_lvl <= w_key_pressed;
      r_key_evt <= w_key_pressed & ~r_key_lvl;
      r_sticky  <= (r_sticky & ~w_clr_bits) | r_key_evt;
    end
  end

  always_comb begin
    w_io_sw = '0;
    w_io_sw[SW_LSB +: SW_WIDTH]      = r_sw_lvl;
    w_io_sw[KEY_LSB +: KEY_WIDTH]    = r_key_lvl;
    w_io_sw[STICKY_LSB +: KEY_WIDTH] = r_sticky;
  end

  assign o_io_sw   = w_io_sw;
  assign o_key_evt = r_key_evt;

endmodule

// File: doc/io_input_cond.md
IO_INPUT_COND -- requirements
Module: io_input_cond

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable synchronized samples needed to accept a change (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 The block SHALL have parameter SW_WIDTH, default 18, meaning the number of slide switches.
REQ-003 The block SHALL have parameter KEY_WIDTH, default 4, meaning the number of push-buttons.
REQ-004 Port i_clk  in  1  SHALL be the single system clock; every flop SHALL be on its rising edge.
REQ-005 Port i_reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 Port i_sw_raw  in  SW_WIDTH  SHALL carry the raw asynchronous switch levels, 1 = up.
REQ-007 Port i_key_raw_n  in  KEY_WIDTH  SHALL carry the raw asynchronous button levels, active-low (0 = pressed).
REQ-008 Port i_clr  in  1  SHALL be a single-cycle strobe that clears sticky press flags; it comes from the LSU store decode.
REQ-009 Port i_clr_mask  in  KEY_WIDTH  SHALL select which sticky flags i_clr clears.
REQ-010 Port o_io_sw  out  32  SHALL be the conditioned input word that drives the LSU i_io_sw port.
REQ-011 Port o_key_evt  out  KEY_WIDTH  SHALL pulse for one cycle per debounced press.

Function
REQ-012 o_io_sw layout SHALL be:
- [SW_WIDTH-1:0]: debounced switch levels
- [23:20]: debounced key levels, 1 = pressed
- [27:24]: sticky press flags
- all other bits: 0
REQ-013 Each raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each bit SHALL have an independent counter of ceil(log2(DEBOUNCE_CYCLES)) bits and a stable register.
REQ-015 Counter behaviour SHALL be as follows when the synchronized value differs from stable:
- Below DEBOUNCE_CYCLES-1: the counter increments.
- At DEBOUNCE_CYCLES-1: stable takes the synchronized value and the counter clears on that same edge.
REQ-016 Whenever the synchronized value equals stable, the counter SHALL clear to 0, so any glitch shorter than DEBOUNCE_CYCLES synchronized samples is rejected with no output change.
REQ-017 Latency SHALL be exactly 2 + DEBOUNCE_CYCLES clock edges from a clean raw transition, sampled at edge 0, to o_io_sw changing.
REQ-018 The counter SHALL never wrap; it saturates by construction at DEBOUNCE_CYCLES-1.
REQ-019 o_key_evt[k] SHALL assert for exactly one cycle, on the cycle after stable key k goes released->pressed; releases SHALL produce no event.
REQ-020 Sticky flag k SHALL set on o_key_evt[k] and hold until cleared.
REQ-021 On an i_clr cycle, sticky flag k SHALL clear when i_clr_mask[k]=1; flags with mask 0 SHALL be unaffected.
REQ-022 If the o_key_evt[k] set and the i_clr clear of flag k fall on the same cycle, set SHALL win (flag = 1).
REQ-023 i_clr held high for multiple cycles SHALL repeat the clear on every cycle; there is no edge detection.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-025 While i_reset=0, asynchronously:
- switch synchronizers and stable registers = 0
- key synchronizers = 1 (released, raw polarity)
- key stable registers = released
- all counters = 0, sticky flags = 0
- o_io_sw = 32'h0, o_key_evt = 0
REQ-026 Reset asserted mid-debounce SHALL discard the partial count.
REQ-027 After reset release, an input already at a non-reset level SHALL appear after the normal 2 + DEBOUNCE_CYCLES latency.
REQ-028 Reset deassertion SHALL be synchronized externally; this block performs no reset synchronization.

Structure
REQ-029 Package io_pkg SHALL hold the o_io_sw field offsets (SW_LSB=0, KEY_LSB=20, STICKY_LSB=24) and the LSU switch address constant 32'h1001_0000.
REQ-030 One sub-module, debounce_bit, SHALL contain the synchronizer, counter and stable register for one bit, with parameters DEBOUNCE_CYCLES and RESET_VAL.
REQ-031 debounce_bit SHALL be instantiated SW_WIDTH + KEY_WIDTH times via generate.
REQ-032 Edge detect, sticky logic and word packing SHALL live in io_input_cond.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=18, KEY_WIDTH=4)
REQ-033 Reset with i_sw_raw=18'h3FFFF and i_key_raw_n=4'hF -> o_io_sw=32'h0 during reset; o_io_sw=32'h0003_FFFF exactly 6 edges after release.
REQ-034 i_sw_raw[0] 0->1 for 3 cycles then back to 0 -> o_io_sw[0] stays 0; the same pulse held for 4 cycles -> o_io_sw[0]=1 at edge 6.
REQ-035 i_key_raw_n=4'b1110 held -> o_io_sw[20]=1 and o_key_evt=4'b0001 for exactly one cycle; then o_io_sw[24]=1; key release -> o_io_sw[20]=0, o_io_sw[24] stays 1, no event.
REQ-036 With sticky=4'b0011, i_clr=1 and i_clr_mask=4'b0001 for one cycle -> o_io_sw[27:24]=4'b0010.
REQ-037 o_key_evt[1] on the same cycle as i_clr with i_clr_mask=4'b0010 -> o_io_sw[25]=1 (set wins).
REQ-038 i_reset pulsed low at count 2 of a pending switch change -> o_io_sw unchanged; after release the change appears 6 edges later.
